// File: rtl/asi_usr_slave.sv
// Single-port user-side memory slave with a write/read grant arbiter and a
// SLV_WS-deep read pipeline. Define ASI_USR_RDATA_HOLD_EN to hold the last read beat.
module asi_usr_slave #(
  parameter int AXI_DW   = 128,
  parameter int AXI_AW   = 32,
  parameter int AXI_SW   = 3,
  parameter int MEM_AW   = 10,
  parameter int SLV_WS   = 1,
  parameter int ASI_ARB  = 0,
  parameter int MAX_SIZE = $clog2(AXI_DW/8)
) (
  input  logic                  usr_clk,
  input  logic                  usr_reset,
  input  logic                  usr_rrequest,
  output logic                  usr_rgrant,
  input  logic [AXI_AW-1:0]     usr_raddr,
  input  logic                  usr_re,
  input  logic                  usr_rlast,
  input  logic [AXI_SW-1:0]     usr_rsize,
  output logic [AXI_DW-1:0]     usr_rdata,
  output logic                  usr_rsize_error,
  input  logic                  usr_wrequest,
  output logic                  usr_wgrant,
  input  logic [AXI_AW-1:0]     usr_waddr,
  input  logic                  usr_we,
  input  logic                  usr_wlast,
  input  logic [AXI_DW-1:0]     usr_wdata,
  input  logic [AXI_DW/8-1:0]   usr_wstrb,
  input  logic [AXI_SW-1:0]     usr_wsize,
  output logic                  usr_wsize_error
);

  localparam int AXI_WSTRBW = AXI_DW / 8;
  localparam int BYTE_AW    = $clog2(AXI_WSTRBW);
  localparam int DEPTH      = 2 ** MEM_AW;
  localparam logic [AXI_SW-1:0] MAX_SIZE_W = AXI_SW'(MAX_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WGNT = 2'd1,
    ST_RGNT = 2'd2
  } state_e;

  state_e r_state;
  state_e w_state_nxt;
  state_e w_pick;

  logic              w_wbeat;
  logic              w_rbeat;
  logic              w_mem_wr;
  logic [MEM_AW-1:0] w_widx;
  logic [MEM_AW-1:0] w_ridx;
  logic [AXI_DW-1:0] w_rd_word;
  logic              w_out_vld;
  logic [AXI_DW-1:0] w_out_data;
  logic              w_unused;

  // Grant choice from the current requests; used from IDLE and on burst end.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_pick = ST_IDLE;
    if (usr_wrequest && usr_rrequest) begin
      w_pick = (ASI_ARB == 0) ? ST_WGNT : ST_RGNT;
    end else if (usr_wrequest) begin
      w_pick = ST_WGNT;
    end else if (usr_rrequest) begin
      w_pick = ST_RGNT;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = w_pick;
      ST_WGNT: if (usr_we && usr_wlast) w_state_nxt = w_pick;
      ST_RGNT: if (usr_re && usr_rlast) w_state_nxt = w_pick;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge usr_clk) begin
    if (usr_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign usr_wgrant      = (r_state == ST_WGNT);
  assign usr_rgrant      = (r_state == ST_RGNT);
  assign usr_wsize_error = (usr_wsize > MAX_SIZE_W);
  assign usr_rsize_error = (usr_rsize > MAX_SIZE_W);

  // Strobes outside the matching grant are ignored entirely.
  assign w_wbeat  = usr_wgrant && usr_we;
  assign w_rbeat  = usr_rgrant && usr_re && !usr_reset;
  assign w_mem_wr = w_wbeat && !usr_wsize_error && !usr_reset;
  assign w_widx   = usr_waddr[BYTE_AW +: MEM_AW];
  assign w_ridx   = usr_raddr[BYTE_AW +: MEM_AW];

  // Upper address bits wrap by design; low bits are sub-word byte offsets.
  assign w_unused = ^{usr_raddr, usr_waddr};

  logic [AXI_DW-1:0] r_mem [DEPTH];

  // NOTE: memory has no reset branch; contents survive usr_reset and map to RAM.
  always_ff @(posedge usr_clk) begin
    if (w_mem_wr) begin
      for (int b = 0; b < AXI_WSTRBW; b++) begin
        if (usr_wstrb[b]) begin
          r_mem[w_widx][8*b +: 8] <= usr_wdata[8*b +: 8];
        end
      end
    end
  end

  assign w_rd_word = r_mem[w_ridx];

  generate
    if (SLV_WS == 0) begin : g_rd_comb
      assign w_out_vld  = w_rbeat;
      assign w_out_data = w_rd_word;
    end else begin : g_rd_pipe
      logic [SLV_WS-1:0] r_pipe_vld;
      logic [AXI_DW-1:0] r_pipe_data [SLV_WS];

      always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
          r_pipe_vld <= '0;
        end else begin
          r_pipe_vld[0] <= w_rbeat;
          for (int s = 1; s < SLV_WS; s++) begin
            r_pipe_vld[s] <= r_pipe_vld[s-1];
          end
        end
      end

      // Data stages need no reset: the output is qualified by the valid flags.
      always_ff @(posedge usr_clk) begin
        if (w_rbeat) begin
          r_pipe_data[0] <= w_rd_word;
        end
        for (int s = 1; s < SLV_WS; s++) begin
          if (r_pipe_vld[s-1]) begin
            r_pipe_data[s] <= r_pipe_data[s-1];
          end
        end
      end

      assign w_out_vld  = r_pipe_vld[SLV_WS-1];
      assign w_out_data = r_pipe_data[SLV_WS-1];
    end
  endgenerate

`ifdef ASI_USR_RDATA_HOLD_EN
  logic [AXI_DW-1:0] r_rdata_hold;

  always_ff @(posedge usr_clk) begin
    if (usr_reset) begin
      r_rdata_hold <= '0;
    end else if (w_out_vld) begin
      r_rdata_hold <= w_out_data;
    end
  end

  assign usr_rdata = w_out_vld ? w_out_data : r_rdata_hold;
`else
  assign usr_rdata = w_out_vld ? w_out_data : '0;
`endif

endmodule

// File: tb/tb_asi_usr_slave.sv
// Scoreboard bench for asi_usr_slave: two instances (SLV_WS=1 and SLV_WS=3) share
// one randomized stimulus stream and are checked against a behavioural memory model.
module tb_asi_usr_slave;

  localparam int DW     = 128;
  localparam int AW     = 32;
  localparam int SW     = 3;
  localparam int MAW    = 10;
  localparam int ARB    = 0;
  localparam int BYTES  = DW / 8;
  localparam int MAX_SZ = $clog2(BYTES);
  localparam int DEPTH  = 1024;

  logic            usr_clk = 1'b0;
  logic            usr_reset = 1'b1;
  logic            usr_rrequest = 1'b0;
  logic [AW-1:0]   usr_raddr = '0;
  logic            usr_re = 1'b0;
  logic            usr_rlast = 1'b0;
  logic [SW-1:0]   usr_rsize = 3'd4;
  logic            usr_wrequest = 1'b0;
  logic [AW-1:0]   usr_waddr = '0;
  logic            usr_we = 1'b0;
  logic            usr_wlast = 1'b0;
  logic [DW-1:0]   usr_wdata = '0;
  logic [BYTES-1:0] usr_wstrb = '0;
  logic [SW-1:0]   usr_wsize = 3'd4;

  logic            ws1_rgrant, ws1_wgrant, ws1_rse, ws1_wse;
  logic [DW-1:0]   ws1_rdata;
  logic            ws3_rgrant, ws3_wgrant, ws3_rse, ws3_wse;
  logic [DW-1:0]   ws3_rdata;

  asi_usr_slave #(.AXI_DW(DW), .AXI_AW(AW), .AXI_SW(SW), .MEM_AW(MAW), .SLV_WS(1), .ASI_ARB(ARB)) u_ws1 (
    .usr_clk(usr_clk), .usr_reset(usr_reset),
    .usr_rrequest(usr_rrequest), .usr_rgrant(ws1_rgrant), .usr_raddr(usr_raddr),
    .usr_re(usr_re), .usr_rlast(usr_rlast), .usr_rsize(usr_rsize), .usr_rdata(ws1_rdata),
    .usr_rsize_error(ws1_rse),
    .usr_wrequest(usr_wrequest), .usr_wgrant(ws1_wgrant), .usr_waddr(usr_waddr),
    .usr_we(usr_we), .usr_wlast(usr_wlast), .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb),
    .usr_wsize(usr_wsize), .usr_wsize_error(ws1_wse)
  );

  asi_usr_slave #(.AXI_DW(DW), .AXI_AW(AW), .AXI_SW(SW), .MEM_AW(MAW), .SLV_WS(3), .ASI_ARB(ARB)) u_ws3 (
    .usr_clk(usr_clk), .usr_reset(usr_reset),
    .usr_rrequest(usr_rrequest), .usr_rgrant(ws3_rgrant), .usr_raddr(usr_raddr),
    .usr_re(usr_re), .usr_rlast(usr_rlast), .usr_rsize(usr_rsize), .usr_rdata(ws3_rdata),
    .usr_rsize_error(ws3_rse),
    .usr_wrequest(usr_wrequest), .usr_wgrant(ws3_wgrant), .usr_waddr(usr_waddr),
    .usr_we(usr_we), .usr_wlast(usr_wlast), .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb),
    .usr_wsize(usr_wsize), .usr_wsize_error(ws3_wse)
  );

  always #5 usr_clk = ~usr_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum {M_IDLE, M_W, M_R} owner_e;
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  owner_e        m_owner = M_IDLE;
  exp_t          q1[$];
  exp_t          q3[$];
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] last1 = '0;
  logic [DW-1:0] last3 = '0;

  function automatic owner_e pick(input bit wr, input bit rd);
    if (wr && rd) return (ARB == 0) ? M_W : M_R;
    if (wr) return M_W;
    if (rd) return M_R;
    return M_IDLE;
  endfunction

  function automatic int widx(input logic [AW-1:0] a);
    return int'((a / BYTES) % DEPTH);
  endfunction

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Edge k: a read sampled here shows up in cycle k + WS - 1 (cycle k follows edge k).
  always @(posedge usr_clk) begin
    exp_t e;
    cyc++;
    if (usr_reset) begin
      m_owner = M_IDLE;
      q1.delete();
      q3.delete();
      last1 = '0;
      last3 = '0;
    end else begin
      case (m_owner)
        M_IDLE: m_owner = pick(usr_wrequest, usr_rrequest);
        M_W: if (usr_we) begin
          if (int'(usr_wsize) <= MAX_SZ) begin
            for (int b = 0; b < BYTES; b++) begin
              if (usr_wstrb[b]) mem_m[widx(usr_waddr)][8*b +: 8] = usr_wdata[8*b +: 8];
            end
          end
          if (usr_wlast) m_owner = pick(usr_wrequest, usr_rrequest);
        end
        M_R: if (usr_re) begin
          e.data = mem_m[widx(usr_raddr)];
          e.due  = cyc;
          q1.push_back(e);
          e.due  = cyc + 2;
          q3.push_back(e);
          if (usr_rlast) m_owner = pick(usr_wrequest, usr_rrequest);
        end
        default: m_owner = M_IDLE;
      endcase
    end
  end

  // ---------------- monitor ----------------
  always @(negedge usr_clk) begin
    logic [DW-1:0] e1, e3;
    exp_t t;
    if (mon_en) begin
      check("wgrant_ws1", ws1_wgrant, m_owner == M_W);
      check("rgrant_ws1", ws1_rgrant, m_owner == M_R);
      check("wgrant_ws3", ws3_wgrant, m_owner == M_W);
      check("rgrant_ws3", ws3_rgrant, m_owner == M_R);
      check("wsize_err", ws1_wse, int'(usr_wsize) > MAX_SZ);
      check("rsize_err", ws3_rse, int'(usr_rsize) > MAX_SZ);
`ifdef ASI_USR_RDATA_HOLD_EN
      e1 = last1;
      e3 = last3;
`else
      e1 = '0;
      e3 = '0;
`endif
      if (q1.size() > 0 && q1[0].due == cyc) begin
        t = q1.pop_front();
        e1 = t.data;
        last1 = e1;
      end
      if (q3.size() > 0 && q3[0].due == cyc) begin
        t = q3.pop_front();
        e3 = t.data;
        last3 = e3;
      end
      check("rdata_ws1", ws1_rdata, e1);
      check("rdata_ws3", ws3_rdata, e3);
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge usr_clk);
    #1;
  endtask

  task automatic wait_grant(input bit wr, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (wr ? ws1_wgrant : ws1_rgrant) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL grant_timeout write_side=%0d got=no grant expected=grant within 20 cycles", wr);
    end
  endtask

  task automatic clear_strobes();
    usr_we = 1'b0; usr_re = 1'b0; usr_wlast = 1'b0; usr_rlast = 1'b0;
  endtask

  task automatic write_burst(input logic [AW-1:0] addr, input int n, input logic [BYTES-1:0] strb,
                             input logic [SW-1:0] size, input bit fixed, input logic [DW-1:0] d,
                             input bit gaps);
    bit ok;
    clear_strobes();
    usr_wrequest = 1'b1;
    wait_grant(1'b1, ok);
    if (!ok) begin
      usr_wrequest = 1'b0;
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        usr_we = 1'b0; usr_wlast = 1'b0;
        tick();
      end
      usr_we    = 1'b1;
      usr_waddr = addr + AW'(i * BYTES);
      usr_wdata = fixed ? d : rnd();
      usr_wstrb = strb;
      usr_wsize = size;
      usr_wlast = (i == n - 1);
      if (i == n - 1) usr_wrequest = 1'b0;
      tick();
    end
    usr_we = 1'b0; usr_wlast = 1'b0; usr_wsize = 3'd4;
  endtask

  task automatic read_burst(input logic [AW-1:0] addr, input int n, input logic [SW-1:0] size,
                            input bit gaps);
    bit ok;
    clear_strobes();
    usr_rrequest = 1'b1;
    wait_grant(1'b0, ok);
    if (!ok) begin
      usr_rrequest = 1'b0;
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        usr_re = 1'b0; usr_rlast = 1'b0;
        tick();
      end
      usr_re    = 1'b1;
      usr_raddr = addr + AW'(i * BYTES);
      usr_rsize = size;
      usr_rlast = (i == n - 1);
      if (i == n - 1) usr_rrequest = 1'b0;
      tick();
    end
    usr_re = 1'b0; usr_rlast = 1'b0; usr_rsize = 3'd4;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=still running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] a5;
    bit ok;
    a5 = {16{8'hA5}};
    repeat (3) tick();
    usr_reset = 1'b0;
    mon_en = 1'b1;
    check("reset_wgrant", ws1_wgrant, '0);
    check("reset_rgrant", ws1_rgrant, '0);
    check("reset_rdata_ws3", ws3_rdata, '0);

    // Fill every word so all later reads have defined expectations.
    write_burst(32'h0, DEPTH, '1, 3'd4, 1'b0, '0, 1'b0);

    // Back-to-back write then read of 0x40.
    write_burst(32'h40, 1, '1, 3'd4, 1'b1, a5, 1'b0);
    read_burst(32'h40, 1, 3'd4, 1'b0);
    check("b2b_rdata", ws1_rdata, a5);

    // Simultaneous requests from IDLE: write first, read granted right after wlast.
    usr_wrequest = 1'b1;
    usr_rrequest = 1'b1;
    tick();
    check("simul_wgrant", ws1_wgrant, 1'b1);
    check("simul_rgrant", ws1_rgrant, 1'b0);
    write_burst(32'h100, 4, '1, 3'd4, 1'b0, '0, 1'b0);
    check("handover_rgrant", ws1_rgrant, 1'b1);
    read_burst(32'h100, 4, 3'd4, 1'b0);

    // Single-byte strobe onto a zeroed word.
    write_burst(32'h80, 1, '1, 3'd4, 1'b1, '0, 1'b0);
    d = rnd();
    write_burst(32'h80, 1, 16'h0001, 3'd4, 1'b1, d, 1'b0);
    read_burst(32'h80, 1, 3'd4, 1'b0);
    check("strb_byte0", ws1_rdata, {120'b0, d[7:0]});

    // Address wrap: 0x4000 aliases word 0.
    d = rnd();
    write_burst(32'h4000, 1, '1, 3'd4, 1'b1, d, 1'b0);
    read_burst(32'h0, 1, 3'd4, 1'b0);
    check("wrap_rdata", ws1_rdata, d);

    // Oversized write is dropped; oversized read still returns data.
    usr_wsize = 3'd5;
    #1;
    check("wsize_err_flag", ws1_wse, 1'b1);
    write_burst(32'h40, 1, '1, 3'd5, 1'b1, rnd(), 1'b0);
    read_burst(32'h40, 1, 3'd7, 1'b0);
    check("wsize_err_nowrite", ws1_rdata, a5);

    // Reset in the middle of a read burst with beats in flight in the WS=3 pipe.
    clear_strobes();
    usr_rrequest = 1'b1;
    wait_grant(1'b0, ok);
    for (int i = 0; i < 3; i++) begin
      usr_re = 1'b1;
      usr_raddr = AW'(i * BYTES);
      tick();
    end
    usr_reset = 1'b1;
    tick();
    usr_reset = 1'b0;
    usr_re = 1'b0;
    usr_rrequest = 1'b0;
    check("rst_wgrant", ws1_wgrant, '0);
    check("rst_rgrant", ws3_rgrant, '0);
    check("rst_rdata_ws1", ws1_rdata, '0);
    check("rst_rdata_ws3", ws3_rdata, '0);
    repeat (4) tick();

    // Randomized bursts with gaps, stray strobes and occasional size errors.
    for (int it = 0; it < 40; it++) begin
      logic [AW-1:0] addr;
      int n;
      addr = $urandom & ~32'hF;
      n = $urandom_range(1, 4);
      if ($urandom_range(1) == 1) begin
        write_burst(addr, n, BYTES'($urandom), SW'($urandom_range(7)), 1'b0, '0, 1'b1);
      end else begin
        read_burst(addr, n, SW'($urandom_range(7)), 1'b1);
      end
      repeat ($urandom_range(0, 2)) begin
        usr_we = 1'($urandom); usr_re = 1'($urandom);
        usr_wlast = 1'b1; usr_rlast = 1'b1;
        usr_waddr = 32'h40; usr_raddr = $urandom & ~32'hF;
        tick();
      end
      clear_strobes();
    end

    repeat (6) tick();
    check("drain_ws1", DW'(q1.size()), '0);
    check("drain_ws3", DW'(q3.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
